// File: rtl/core_pkg.sv
// Shared RV32I core constants: datapath widths and the major opcodes used to
// classify issuing instructions.
package core_pkg;

    localparam int unsigned XLEN       = 32;
    localparam int unsigned NREG       = 32;
    localparam int unsigned REG_ADDR_W = $clog2(NREG);
    localparam int unsigned PCNT_W     = REG_ADDR_W + 1;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    function automatic logic is_long_latency(input logic [6:0] opcode);
        return opcode == OP_LOAD;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, a running count of busy
// registers, and the read-hazard detector for both read ports.
module regfile_scoreboard
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  issue_en,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_long,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  hazard,
    output logic [PCNT_W-1:0]     pending_cnt
);

    logic [NREG-1:0]   busy_q, busy_d;
    logic [PCNT_W-1:0] cnt_q, cnt_d;
    logic              set_v, clr_v, inc, dec;
    logic              h1, h2;

    assign set_v = issue_en & issue_long & (issue_rd != '0);
    assign clr_v = wb_en & (wb_rd != '0);

    always_comb begin
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            // Set wins: a back-to-back load to the same rd must stay pending.
            if (set_v && issue_rd == REG_ADDR_W'(r)) begin
                busy_d[r] = 1'b1;
            end else if (clr_v && wb_rd == REG_ADDR_W'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
        busy_d[0] = 1'b0;
    end

    assign inc = set_v & ~busy_q[issue_rd];
    assign dec = clr_v & busy_q[wb_rd] & ~(set_v & (issue_rd == wb_rd));

    always_comb begin
        cnt_d = cnt_q + PCNT_W'(inc) - PCNT_W'(dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign h1 = busy_q[rs1_addr] & (rs1_addr != '0) & ~(wb_en & (wb_rd == rs1_addr));
    assign h2 = busy_q[rs2_addr] & (rs2_addr != '0) & ~(wb_en & (wb_rd == rs2_addr));
    assign hazard      = h1 | h2;
    assign pending_cnt = cnt_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (32'(cnt_q) == $countones(busy_q))
                else $error("pending count %0d disagrees with busy bits", cnt_q);
        end
    end
`endif

endmodule

// File: rtl/regfile_wb.sv
// RV32I integer register bank: x0 hardwired to zero, two combinational read
// ports with same-cycle write-back bypass, and a load scoreboard.
module regfile_wb
    import core_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    input  logic                  issue_en,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_long,
    output logic                  hazard,
    output logic [PCNT_W-1:0]     pending_cnt
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];

    always_comb begin
        regs_d = regs_q;
        if (wb_en && wb_rd != '0) begin
            regs_d[wb_rd] = wb_data;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        if (rs1_addr == '0) begin
            rs1_data = '0;
        end else if (wb_en && wb_rd == rs1_addr) begin
            rs1_data = wb_data;
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
    end

    always_comb begin
        if (rs2_addr == '0) begin
            rs2_data = '0;
        end else if (wb_en && wb_rd == rs2_addr) begin
            rs2_data = wb_data;
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
    end

    regfile_scoreboard u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .issue_long  (issue_long),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .hazard      (hazard),
        .pending_cnt (pending_cnt)
    );

endmodule

// File: tb/tb_regfile_wb.sv
// Self-checking bench for regfile_wb: directed scenarios followed by random
// traffic, all checked against an array-based reference model.
module tb_regfile_wb;
    import core_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  wb_en;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [XLEN-1:0]       wb_data;
    logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr;
    logic [XLEN-1:0]       rs1_data, rs2_data;
    logic                  issue_en;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  issue_long;
    logic                  hazard;
    logic [PCNT_W-1:0]     pending_cnt;

    int total = 0;
    int bad   = 0;

    // Reference state
    logic [XLEN-1:0] m_regs [NREG];
    bit              m_busy [NREG];

    always #5 clk = ~clk;

    regfile_wb dut (
        .clk         (clk),
        .rst         (rst),
        .wb_en       (wb_en),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .issue_en    (issue_en),
        .issue_rd    (issue_rd),
        .issue_long  (issue_long),
        .hazard      (hazard),
        .pending_cnt (pending_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [XLEN-1:0] m_read(input logic [REG_ADDR_W-1:0] a);
        if (a == 0) return '0;
        if (wb_en && wb_rd == a) return wb_data;
        return m_regs[a];
    endfunction

    function automatic bit m_hz(input logic [REG_ADDR_W-1:0] a);
        return a != 0 && m_busy[a] && !(wb_en && wb_rd == a);
    endfunction

    function automatic int m_pending();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic idle();
        wb_en = 0; wb_rd = 0; wb_data = 0;
        issue_en = 0; issue_rd = 0; issue_long = 0;
        rs1_addr = 0; rs2_addr = 0;
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                m_regs[i] = '0;
                m_busy[i] = 0;
            end
        end else begin
            if (wb_en && wb_rd != 0) begin
                m_regs[wb_rd] = wb_data;
                m_busy[wb_rd] = 0;
            end
            if (issue_en && issue_long && issue_rd != 0) m_busy[issue_rd] = 1;
        end
    endtask

    // Inputs are driven just after the falling edge; compare, clock, update model.
    task automatic step();
        #1;
        check_eq("rs1_data", rs1_data, m_read(rs1_addr));
        check_eq("rs2_data", rs2_data, m_read(rs2_addr));
        check_eq("hazard", 32'(hazard), 32'(m_hz(rs1_addr) | m_hz(rs2_addr)));
        check_eq("pending_cnt", 32'(pending_cnt), 32'(m_pending()));
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    initial begin
        idle();
        rst = 1;
        for (int i = 0; i < NREG; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 0;
        end
        @(negedge clk);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 0;

        #1;
        check_eq("rst_pending", 32'(pending_cnt), 0);
        check_eq("rst_hazard", 32'(hazard), 0);
        rs1_addr = 5; rs2_addr = 31;
        #1;
        check_eq("rst_rs1", rs1_data, 0);
        check_eq("rst_rs2", rs2_data, 0);
        step();

        // Same-cycle bypass, then the stored value.
        idle(); wb_en = 1; wb_rd = 5; wb_data = 32'hDEADBEEF; rs1_addr = 5;
        #1; check_eq("bypass_rs1", rs1_data, 32'hDEADBEEF);
        step();
        idle(); rs1_addr = 5;
        #1; check_eq("stored_rs1", rs1_data, 32'hDEADBEEF);
        step();

        // x0 writes are discarded.
        idle(); wb_en = 1; wb_rd = 0; wb_data = 32'h12345678;
        #1; check_eq("x0_byp_rs1", rs1_data, 0); check_eq("x0_byp_rs2", rs2_data, 0);
        step();
        idle();
        #1; check_eq("x0_rs1", rs1_data, 0); check_eq("x0_rs2", rs2_data, 0);
        step();

        // Load to x7, hazard until its write-back.
        idle(); issue_en = 1; issue_long = 1; issue_rd = 7;
        step();
        idle(); rs2_addr = 7;
        #1; check_eq("ld7_hazard", 32'(hazard), 1); check_eq("ld7_pend", 32'(pending_cnt), 1);
        step();
        idle(); wb_en = 1; wb_rd = 7; wb_data = 32'hA5A5A5A5; rs2_addr = 7;
        #1; check_eq("wb7_hazard", 32'(hazard), 0); check_eq("wb7_rs2", rs2_data, 32'hA5A5A5A5);
        step();
        idle();
        #1; check_eq("wb7_pend", 32'(pending_cnt), 0);
        step();

        // Write-back and a new load to the same rd on one edge: stays pending.
        idle(); issue_en = 1; issue_long = 1; issue_rd = 9;
        step();
        idle(); wb_en = 1; wb_rd = 9; wb_data = 32'h1; issue_en = 1; issue_long = 1; issue_rd = 9;
        step();
        idle(); rs1_addr = 9;
        #1; check_eq("x9_hazard", 32'(hazard), 1); check_eq("x9_pend", 32'(pending_cnt), 1);
        step();
        idle(); wb_en = 1; wb_rd = 9; wb_data = 32'h99;
        step();

        // Fill the scoreboard, then reset mid-operation.
        for (int r = 1; r < NREG; r++) begin
            idle(); issue_en = 1; issue_long = 1; issue_rd = REG_ADDR_W'(r);
            step();
        end
        idle();
        #1; check_eq("full_pend", 32'(pending_cnt), 31);
        rst = 1; wb_en = 1; wb_rd = 5; wb_data = 32'hFFFF0000;
        step();
        rst = 0; idle(); rs1_addr = 5; rs2_addr = 31;
        #1;
        check_eq("rst2_pend", 32'(pending_cnt), 0);
        check_eq("rst2_hazard", 32'(hazard), 0);
        check_eq("rst2_rs1", rs1_data, 0);
        check_eq("rst2_rs2", rs2_data, 0);
        step();

        // Non-load issue and a load to x0 leave the scoreboard alone.
        idle(); issue_en = 1; issue_long = 0; issue_rd = 3;
        step();
        idle(); rs1_addr = 3;
        #1; check_eq("nonld_hazard", 32'(hazard), 0);
        step();
        idle(); issue_en = 1; issue_long = 1; issue_rd = 0;
        step();
        idle();
        #1; check_eq("ld0_pend", 32'(pending_cnt), 0);
        step();

        // Random traffic; narrow address pool on some cycles to provoke collisions.
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] lim;
            lim = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'd7;
            rst        = ($urandom_range(0, 199) == 0);
            wb_en      = $urandom_range(0, 1) == 1;
            wb_rd      = REG_ADDR_W'($urandom_range(0, int'(lim)));
            wb_data    = $urandom;
            issue_en   = $urandom_range(0, 1) == 1;
            issue_long = ($urandom_range(0, OP_STORE == 0 ? 1 : 2) != 0);
            issue_rd   = REG_ADDR_W'($urandom_range(0, int'(lim)));
            rs1_addr   = REG_ADDR_W'($urandom_range(0, int'(lim)));
            rs2_addr   = REG_ADDR_W'($urandom_range(0, int'(lim)));
            step();
        end
        rst = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
